// File: rtl/activation_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | activation_unit: neuron activation stage (sigmoid ROMs, ReLU, pass-through).   |
// | Revision: 1.0                                                                  |
// +--------------------------------------------------------------------------------+

package act_pkg;
  // round(sigmoid(v / 2^frac_bits) * 2^(out_bits-1)) in Q60 integer arithmetic,
  // so the table is built identically by every elaborating tool.
  function automatic int sig_entry(int v, int frac_bits, int out_bits, bit clamp);
    logic [127:0] one, c, term, p, e, n, d, q, maxv;
    int m;
    one  = 128'd1 << 60;
    c    = one;
    term = one;
    for (int k = 1; k < 24; k++) begin
      term = term / (128'(k) << frac_bits);
      if (k % 2 == 1) c = c - term;
      else            c = c + term;
    end
    m = (v < 0) ? -v : v;
    e = one;
    p = c;
    for (int j = 0; j < 31; j++) begin
      if (((m >> j) & 1) == 1) e = (e * p) >> 60;
      p = (p * p) >> 60;
    end
    n    = ((v < 0) ? e : one) << (out_bits - 1);
    d    = one + e;
    q    = ((n << 1) + d) / (d << 1);
    maxv = (128'd1 << (out_bits - 1)) - 128'd1;
    if (clamp && (q > maxv)) q = maxv;
    return int'(q[31:0]);
  endfunction
endpackage

module Sig_ROM #(
  parameter int DATA_WIDTH   = 16,
  parameter int SIGMOID_SIZE = 10,
  parameter int X_FRAC_BITS  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIGMOID_SIZE-1:0] x_i,
  output logic [DATA_WIDTH-1:0]   y_o
);
  localparam int DEPTH = 2 ** SIGMOID_SIZE;

  logic [DATA_WIDTH-1:0]   rom [DEPTH];
  logic [SIGMOID_SIZE-1:0] addr;
  logic [DATA_WIDTH-1:0]   y_q;

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam int VAL = act_pkg::sig_entry(a - DEPTH / 2, X_FRAC_BITS, DATA_WIDTH, 1'b1);
    assign rom[a] = DATA_WIDTH'(VAL);
  end

  // Offset-binary address: x + 2^(SIGMOID_SIZE-1) is just the MSB inverted.
  assign addr = {~x_i[SIGMOID_SIZE-1], x_i[SIGMOID_SIZE-2:0]};

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= rom[addr];
  end

  assign y_o = y_q;
endmodule

module Sig_LU_ROM_HALF #(
  parameter int DATA_WIDTH   = 16,
  parameter int SIGMOID_SIZE = 10,
  parameter int X_FRAC_BITS  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIGMOID_SIZE-1:0] x_i,
  input  logic                    s_i,
  output logic [DATA_WIDTH-1:0]   y_o
);
  localparam int HDEPTH = 2 ** (SIGMOID_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MAXP = HALF - DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0]   rom [HDEPTH];
  logic [SIGMOID_SIZE-1:0] neg_x;
  logic [SIGMOID_SIZE-2:0] m;
  logic [DATA_WIDTH-1:0]   g, y_d, y_q;

  // Entries are stored unclamped (top entries may equal 2^(DATA_WIDTH-1)) so the
  // negative mirror reaches exactly 0; the positive side clamps on the way out.
  for (genvar a = 0; a < HDEPTH; a++) begin : g_rom
    localparam int VAL = act_pkg::sig_entry(a, X_FRAC_BITS, DATA_WIDTH, 1'b0);
    assign rom[a] = DATA_WIDTH'(VAL);
  end

  always_comb begin
    neg_x = -x_i;
    if (!x_i[SIGMOID_SIZE-1])        m = x_i[SIGMOID_SIZE-2:0];
    else if (neg_x[SIGMOID_SIZE-1])  m = '1;
    else                             m = neg_x[SIGMOID_SIZE-2:0];
    g = rom[m];
    if (s_i)            y_d = HALF - g;
    else if (g == HALF) y_d = MAXP;
    else                y_d = g;
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y_o = y_q;
endmodule

module ReLU #(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*DATA_WIDTH-1:0]   sum_i,
  output logic [DATA_WIDTH-1:0]     y_o
);
  localparam int SW = 2 * DATA_WIDTH;
  localparam int H  = SW - 1 - WEIGHT_INT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAXP = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH-1:0] y_d, y_q;
  logic                  unused_low;

  assign unused_low = ^sum_i[H-DATA_WIDTH:0];

  always_comb begin
    if (sum_i[SW-1])        y_d = '0;
    else if (|sum_i[SW-2:H]) y_d = MAXP;
    else                    y_d = sum_i[H -: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y_o = y_q;
endmodule

module activation_unit #(
  parameter int    DATA_WIDTH       = 16,
  parameter int    WEIGHT_INT_WIDTH = 4,
  parameter int    SIGMOID_SIZE     = 10,
  parameter int    X_FRAC_BITS      = 5,
  parameter string ACT_TYPE         = "sigmoid_LU"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] sum,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    out_valid
);
  localparam int SW = 2 * DATA_WIDTH;
  localparam int H  = SW - 1 - WEIGHT_INT_WIDTH;

  logic [DATA_WIDTH-1:0] act;
  logic                  out_valid_q;
  logic                  ovf;

  // The extracted field is valid only if every bit from the sign down to H agrees.
  assign ovf = !((&sum[SW-1:H]) || !(|sum[SW-1:H]));

  always_ff @(posedge clk) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= in_valid;
  end

  if (ACT_TYPE == "sigmoid_nor" || ACT_TYPE == "sigmoid_LU") begin : g_sigmoid
    logic [SIGMOID_SIZE-1:0] x;
    logic                    unused_low;
    assign unused_low = ^sum[H-SIGMOID_SIZE:0];
    assign x = ovf ? {sum[SW-1], {(SIGMOID_SIZE-1){~sum[SW-1]}}} : sum[H -: SIGMOID_SIZE];
    if (ACT_TYPE == "sigmoid_nor") begin : g_nor
      Sig_ROM #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SIGMOID_SIZE(SIGMOID_SIZE),
        .X_FRAC_BITS (X_FRAC_BITS)
      ) u_rom (
        .clk(clk),
        .rst(rst),
        .x_i(x),
        .y_o(act)
      );
    end else begin : g_lu
      Sig_LU_ROM_HALF #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SIGMOID_SIZE(SIGMOID_SIZE),
        .X_FRAC_BITS (X_FRAC_BITS)
      ) u_rom (
        .clk(clk),
        .rst(rst),
        .x_i(x),
        .s_i(sum[SW-1]),
        .y_o(act)
      );
    end
  end else if (ACT_TYPE == "relu") begin : g_relu
    logic unused_ovf;
    assign unused_ovf = ovf;
    ReLU #(
      .DATA_WIDTH      (DATA_WIDTH),
      .WEIGHT_INT_WIDTH(WEIGHT_INT_WIDTH)
    ) u_relu (
      .clk  (clk),
      .rst  (rst),
      .sum_i(sum),
      .y_o  (act)
    );
  end else begin : g_pass
    logic [DATA_WIDTH-1:0] pass_q;
    logic                  unused_low;
    assign unused_low = ^sum[H-DATA_WIDTH:0];
    always_ff @(posedge clk) begin
      if (rst)      pass_q <= '0;
      else if (ovf) pass_q <= {sum[SW-1], {(DATA_WIDTH-1){~sum[SW-1]}}};
      else          pass_q <= sum[H -: DATA_WIDTH];
    end
    assign act = pass_q;
  end

  assign out       = act;
  assign out_valid = out_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_activation_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | tb_activation_unit: randomized bench for all four activation flavours.         |
// | Revision: 1.0                                                                  |
// +--------------------------------------------------------------------------------+
module tb_activation_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sum = '0;
  logic        in_valid = 1'b0;

  logic [15:0] out_nor, out_lu, out_relu, out_pass;
  logic        v_nor, v_lu, v_relu, v_pass;

  int n_checks = 0;
  int n_pass   = 0;

  activation_unit #(.ACT_TYPE("sigmoid_nor")) u_nor (
    .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid), .out(out_nor), .out_valid(v_nor));
  activation_unit #(.ACT_TYPE("sigmoid_LU")) u_lu (
    .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid), .out(out_lu), .out_valid(v_lu));
  activation_unit #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid), .out(out_relu), .out_valid(v_relu));
  activation_unit #(.ACT_TYPE("linear")) u_pass (
    .clk(clk), .rst(rst), .sum(sum), .in_valid(in_valid), .out(out_pass), .out_valid(v_pass));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv, input int tol = 0);
    n_checks++;
    if ((obs - expv) <= tol && (expv - obs) <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, expv, tol);
  endtask

  // Reference: the sigmoid table entry straight from the real-valued formula.
  function automatic int sig_ref(input int x);
    real r;
    int  e;
    r = 32768.0 / (1.0 + $exp(-real'(x) / 32.0));
    e = $rtoi(r + 0.5);
    return (e > 32767) ? 32767 : e;
  endfunction

  // x = floor(sum / 2^18) saturated to the 10-bit signed range.
  function automatic int x_of(input logic [31:0] s);
    longint v;
    v = longint'($signed(s)) >>> 18;
    if (v > 511)  v = 511;
    if (v < -512) v = -512;
    return int'(v);
  endfunction

  function automatic int relu_ref(input logic [31:0] s);
    longint v;
    v = longint'($signed(s)) >>> 12;
    if (v < 0)     return 0;
    if (v > 32767) return 32767;
    return int'(v);
  endfunction

  function automatic int pass_ref(input logic [31:0] s);
    longint v;
    v = longint'($signed(s)) >>> 12;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic drive_and_check(input logic [31:0] s, input logic v);
    int x;
    sum      = s;
    in_valid = v;
    @(posedge clk);
    #1;
    x = x_of(s);
    check("sig_nor", int'(out_nor), sig_ref(x));
    check("sig_lu", int'(out_lu), sig_ref(x), 1);
    check("relu", int'(out_relu), relu_ref(s));
    check("pass", int'($signed(out_pass)), pass_ref(s));
    check("valid", int'({v_nor, v_lu, v_relu, v_pass}), v ? 15 : 0);
  endtask

  task automatic directed(input logic [31:0] s);
    sum      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;

    // Reset holds everything at zero even with live input.
    rst      = 1'b1;
    sum      = 32'h1234_5678;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", int'({out_nor, out_lu, out_relu, out_pass} != 64'd0), 0);
    check("rst_valid", int'({v_nor, v_lu, v_relu, v_pass}), 0);
    rst = 1'b0;

    directed(32'h0000_0000);
    check("nor_zero", int'(out_nor), 16384);
    check("nor_zero_v", int'(v_nor), 1);
    directed(32'hFF80_0000);
    check("lu_m1", int'(out_lu), 8813);
    check("nor_m1", int'(out_nor), 8813, 1);
    directed(32'h7FFF_FFFF);
    check("lu_max", int'(out_lu), 32767);
    check("nor_max", int'(out_nor), 32767);
    check("pass_max", int'($signed(out_pass)), 32767);
    directed(32'h8000_0000);
    check("lu_min", int'(out_lu), 0);
    check("nor_min", int'(out_nor), 0);
    check("pass_min", int'($signed(out_pass)), -32768);
    directed(32'h0123_4567);
    check("relu_pos", int'(out_relu), 16'h1234);
    directed(32'hFFFF_0000);
    check("relu_neg", int'(out_relu), 0);
    directed(32'h7000_0000);
    check("relu_sat", int'(out_relu), 16'h7FFF);

    // Back-to-back stream, then reset lands mid-stream.
    for (int i = 0; i < 4; i++) drive_and_check($urandom(), 1'b1);
    sum      = 32'h0123_4567;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out", int'({out_nor, out_lu, out_relu, out_pass} != 64'd0), 0);
    check("midrst_valid", int'({v_nor, v_lu, v_relu, v_pass}), 0);
    rst = 1'b0;

    // Every x value, with random fraction bits below the field.
    for (int x = -512; x < 512; x++) begin
      r        = 32'(x) << 18;
      r[17:0]  = 18'($urandom());
      drive_and_check(r, 1'($urandom_range(1, 0)));
    end

    // Random sums, half of them kept inside the non-saturating range.
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      if ($urandom_range(1, 0) == 1) r = {{5{r[27]}}, r[26:0]};
      drive_and_check(r, 1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
